// File: rtl/gate_matrix_pkg.sv
// Shared types and helpers for the gate-matrix loader: element indexing,
// adjoint index mapping and saturating negation.
package gate_matrix_pkg;

  localparam int unsigned NUM_ELEMS     = 8;
  localparam int unsigned ELEM_W        = 3;
  localparam int unsigned ELEM_ROW_BIT  = 2;
  localparam int unsigned ELEM_COL_BIT  = 1;
  localparam int unsigned ELEM_IMAG_BIT = 0;
  localparam int unsigned MAX_DATA_W    = 64;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHit
  } state_e;

  function automatic logic [ELEM_W-1:0] elem_index(input logic row, input logic col,
                                                  input logic imag);
    logic [ELEM_W-1:0] e;
    e                = '0;
    e[ELEM_ROW_BIT]  = row;
    e[ELEM_COL_BIT]  = col;
    e[ELEM_IMAG_BIT] = imag;
    return e;
  endfunction

  function automatic logic [ELEM_W-1:0] adjoint_index(input logic [ELEM_W-1:0] e);
    return elem_index(e[ELEM_COL_BIT], e[ELEM_ROW_BIT], e[ELEM_IMAG_BIT]);
  endfunction

  // x carries a data_w-bit two's-complement value in its low bits.
  function automatic logic [MAX_DATA_W-1:0] sat_neg(input logic [MAX_DATA_W-1:0] x,
                                                   input int unsigned data_w);
    logic [MAX_DATA_W-1:0] one;
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] min_v;
    one   = MAX_DATA_W'(1);
    mask  = (one << data_w) - one;
    min_v = one << (data_w - 1);
    if ((x & mask) == min_v) begin
      return min_v - one;
    end
    return (~x + one) & mask;
  endfunction

endpackage

// File: rtl/gate_matrix_adjoint.sv
// Per-lane capture mapping: routes a ROM component to its destination element,
// applying the conjugate transpose when requested.
module gate_matrix_adjoint
  import gate_matrix_pkg::*;
#(
  parameter int unsigned DATA_W = 19
) (
  input  logic [ELEM_W-1:0] i_cap_idx,
  input  logic              i_adjoint,
  input  logic [DATA_W-1:0] i_cap_val,
  output logic [ELEM_W-1:0] o_dst_idx,
  output logic [DATA_W-1:0] o_dst_val
);

  always_comb begin
    o_dst_idx = i_cap_idx;
    o_dst_val = i_cap_val;
    if (i_adjoint) begin
      o_dst_idx = adjoint_index(i_cap_idx);
      if (i_cap_idx[ELEM_IMAG_BIT]) begin
        o_dst_val = DATA_W'(sat_neg(MAX_DATA_W'(i_cap_val), DATA_W));
      end
    end
  end

endmodule

// File: rtl/gate_matrix_loader.sv
// Fetches one 2x2 complex gate matrix from a synchronous ROM, LANES components
// per word, optionally as its adjoint. GATE_MATRIX_CACHE_EN adds a one-entry tag cache.
module gate_matrix_loader
  import gate_matrix_pkg::*;
#(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned GATE_W = 5,
  parameter int unsigned LANES  = 1,
  localparam int unsigned WORDS  = 8 / LANES,
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int unsigned ADDR_W = GATE_W + WIDX_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [GATE_W-1:0]             req_gate,
  input  logic                          req_adjoint,
  output logic                          req_ready,
  output logic                          rom_en,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [LANES*DATA_W-1:0]       rom_q,
  input  logic                          cache_flush,
  output logic [NUM_ELEMS*DATA_W-1:0]   mat,
  output logic                          mat_valid,
  output logic                          done_pulse
);

  state_e                        r_state;
  state_e                        w_state_next;
  logic                          r_adj;
  logic                          r_rom_en;
  logic [ADDR_W-1:0]             r_rom_addr;
  logic                          r_rd_valid;
  logic [WIDX_W-1:0]             r_rd_widx;
  logic [NUM_ELEMS*DATA_W-1:0]   r_mat;
  logic                          r_mat_valid;
  logic                          r_done;

  logic                          w_accept;
  logic                          w_hit;
  logic                          w_last_cap;
  logic [ELEM_W-1:0]             w_cap_idx [LANES];
  logic [DATA_W-1:0]             w_cap_val [LANES];
  logic [ELEM_W-1:0]             w_dst_idx [LANES];
  logic [DATA_W-1:0]             w_dst_val [LANES];

  assign w_accept   = req_valid && (r_state == StIdle);
  assign w_last_cap = r_rd_valid && (r_rd_widx == WIDX_W'(WORDS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_cap_idx[l] = ELEM_W'(r_rd_widx * LANES + l);
    assign w_cap_val[l] = rom_q[l*DATA_W +: DATA_W];

    gate_matrix_adjoint #(
      .DATA_W (DATA_W)
    ) u_adjoint (
      .i_cap_idx (w_cap_idx[l]),
      .i_adjoint (r_adj),
      .i_cap_val (w_cap_val[l]),
      .o_dst_idx (w_dst_idx[l]),
      .o_dst_val (w_dst_val[l])
    );
  end

`ifdef GATE_MATRIX_CACHE_EN
  logic [GATE_W-1:0] r_tag_gate;
  logic              r_tag_adj;
  logic              r_tag_valid;

  // Flush takes priority over a tag write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_valid <= 1'b0;
      r_tag_gate  <= '0;
      r_tag_adj   <= 1'b0;
    end else if (cache_flush) begin
      r_tag_valid <= 1'b0;
    end else if (w_last_cap) begin
      r_tag_valid <= 1'b1;
      r_tag_gate  <= r_rom_addr[ADDR_W-1:WIDX_W];
      r_tag_adj   <= r_adj;
    end
  end

  assign w_hit = w_accept && r_tag_valid && r_mat_valid && !cache_flush &&
                 (r_tag_gate == req_gate) && (r_tag_adj == req_adjoint);
`else
  logic w_unused_flush;
  assign w_unused_flush = cache_flush;
  assign w_hit          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_hit ? StHit : StLoad;
      StLoad:  if (w_last_cap) w_state_next = StIdle;
      StHit:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_adj       <= 1'b0;
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_widx   <= '0;
      r_mat       <= '0;
      r_mat_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      // ROM data for the word issued last cycle is on rom_q one cycle later.
      r_rd_valid <= r_rom_en;
      r_rd_widx  <= r_rom_addr[WIDX_W-1:0];

      if (w_accept && !w_hit) begin
        r_adj       <= req_adjoint;
        r_mat_valid <= 1'b0;
        r_rom_en    <= 1'b1;
        r_rom_addr  <= {req_gate, {WIDX_W{1'b0}}};
      end else if (r_rom_en) begin
        if (r_rom_addr[WIDX_W-1:0] == WIDX_W'(WORDS - 1)) begin
          r_rom_en <= 1'b0;
        end else begin
          r_rom_addr[WIDX_W-1:0] <= r_rom_addr[WIDX_W-1:0] + 1'b1;
        end
      end

      if (r_rd_valid) begin
        for (int l = 0; l < LANES; l++) begin
          r_mat[w_dst_idx[l]*DATA_W +: DATA_W] <= w_dst_val[l];
        end
      end

      if (w_last_cap) begin
        r_mat_valid <= 1'b1;
        r_done      <= 1'b1;
      end
      if (r_state == StHit) begin
        r_done <= 1'b1;
      end
    end
  end

  assign req_ready  = (r_state == StIdle);
  assign rom_en     = r_rom_en;
  assign rom_addr   = r_rom_addr;
  assign mat        = r_mat;
  assign mat_valid  = r_mat_valid;
  assign done_pulse = r_done;

endmodule

// File: tb/tb_gate_matrix_loader.sv
// Bench for gate_matrix_loader: one LANES=1 and one LANES=4 instance sharing a ROM image.
module tb_gate_matrix_loader;

  localparam int DW = 19;
  localparam int GW = 5;
  localparam int MW = 8 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          rv_a, ra_a, cf_a, rv_b, ra_b, cf_b;
  logic [GW-1:0] rg_a, rg_b;
  logic          rdy_a, ren_a, mv_a, dp_a, rdy_b, ren_b, mv_b, dp_b;
  logic [GW+2:0] addr_a;
  logic [GW:0]   addr_b;
  logic [DW-1:0]   q_a;
  logic [4*DW-1:0] q_b;
  logic [MW-1:0] mat_a, mat_b;

  // Logical ROM image: rom[gate][e], e = {row, col, imag}.
  logic [DW-1:0] rom [32][8];

  int n_checks = 0;
  int n_pass   = 0;

  gate_matrix_loader #(.DATA_W(DW), .GATE_W(GW), .LANES(1)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (rv_a),
    .req_gate    (rg_a),
    .req_adjoint (ra_a),
    .req_ready   (rdy_a),
    .rom_en      (ren_a),
    .rom_addr    (addr_a),
    .rom_q       (q_a),
    .cache_flush (cf_a),
    .mat         (mat_a),
    .mat_valid   (mv_a),
    .done_pulse  (dp_a)
  );

  gate_matrix_loader #(.DATA_W(DW), .GATE_W(GW), .LANES(4)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (rv_b),
    .req_gate    (rg_b),
    .req_adjoint (ra_b),
    .req_ready   (rdy_b),
    .rom_en      (ren_b),
    .rom_addr    (addr_b),
    .rom_q       (q_b),
    .cache_flush (cf_b),
    .mat         (mat_b),
    .mat_valid   (mv_b),
    .done_pulse  (dp_b)
  );

  always @(posedge clk) if (ren_a) q_a <= rom[addr_a[7:3]][addr_a[2:0]];
  always @(posedge clk) begin
    if (ren_b) begin
      for (int l = 0; l < 4; l++) q_b[l*DW +: DW] <= rom[addr_b[5:1]][{addr_b[0], 2'(l)}];
    end
  end

  function automatic logic [DW-1:0] c19(input int v);
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] elem(input logic [MW-1:0] m, input int e);
    return m[e*DW +: DW];
  endfunction

  // Reference: out[r][c] = adj ? conj(M[c][r]) : M[r][c], negation saturating.
  function automatic logic [MW-1:0] model(input int g, input bit adj);
    logic [MW-1:0] m;
    int sr, sc, v;
    m = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 2; i++) begin
          sr = adj ? c : r;
          sc = adj ? r : c;
          v  = int'($signed(rom[g][sr*4 + sc*2 + i]));
          if (adj && i == 1) v = (v == -(1 << (DW - 1))) ? (1 << (DW - 1)) - 1 : -v;
          m[(r*4 + c*2 + i)*DW +: DW] = v[DW-1:0];
        end
      end
    end
    return m;
  endfunction

  function automatic logic get_ren(input int d); return d != 0 ? ren_b : ren_a; endfunction
  function automatic logic get_dp(input int d);  return d != 0 ? dp_b : dp_a;   endfunction
  function automatic logic get_mv(input int d);  return d != 0 ? mv_b : mv_a;   endfunction
  function automatic logic get_rdy(input int d); return d != 0 ? rdy_b : rdy_a; endfunction
  function automatic logic [MW-1:0] get_mat(input int d);
    return d != 0 ? mat_b : mat_a;
  endfunction
  function automatic logic [GW-1:0] get_gate(input int d);
    return d != 0 ? addr_b[5:1] : addr_a[7:3];
  endfunction
  function automatic int get_word(input int d);
    return d != 0 ? int'(addr_b[0]) : int'(addr_a[2:0]);
  endfunction

  task automatic set_in(input int d, input logic v, input logic [GW-1:0] g, input logic adj,
                        input logic f);
    if (d == 0) begin
      rv_a = v; rg_a = g; ra_a = adj; cf_a = f;
    end else begin
      rv_b = v; rg_b = g; ra_b = adj; cf_b = f;
    end
  endtask

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge where done_pulse is seen (or on timeout).
  // lat counts edges from accept to done_pulse; poke drives a stray request at that cycle.
  task automatic run_load(input int d, input int g, input bit adj, input bit fsh, input int poke,
                          output int lat, output int nrom, output bit bad, output logic mv0);
    lat  = -1;
    nrom = 0;
    bad  = 1'b0;
    mv0  = 1'b1;
    set_in(d, 1'b1, GW'(g), adj, fsh);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == poke) set_in(d, 1'b1, GW'(g ^ 1), adj, 1'b0);
      else set_in(d, 1'b0, GW'(g), adj, 1'b0);
      if (i == 0) mv0 = get_mv(d);
      if (get_ren(d)) begin
        if (get_gate(d) != GW'(g) || get_word(d) != nrom) bad = 1'b1;
        nrom++;
      end
      if (get_dp(d)) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
  endtask

  typedef struct {
    int d;
    int g;
    bit adj;
    int lat;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int lat, nrom, ndp, d, g, poke;
    bit bad, adj;
    logic mv0;
    logic [MW-1:0] m;

    for (int gi = 0; gi < 32; gi++) begin
      for (int e = 0; e < 8; e++) begin
        rom[gi][e] = ($urandom_range(0, 7) == 0) ? 19'h40000 : DW'($urandom);
      end
    end
    for (int e = 0; e < 8; e++) rom[3][e] = '0;
    rom[3][0] = c19(16384);
    rom[3][6] = c19(16384);
    rom[1][2] = c19(100);
    rom[1][3] = c19(50);
    rom[1][4] = c19(-7);
    rom[1][5] = c19(3);
    rom[7][1] = c19(-262144);
    rom[7][3] = c19(-262144);

    tbl[0] = '{0, 3, 1'b0, 9};
    tbl[1] = '{1, 1, 1'b1, 3};
    tbl[2] = '{0, 7, 1'b1, 9};
    tbl[3] = '{1, 7, 1'b1, 3};
    tbl[4] = '{1, 3, 1'b0, 3};
    tbl[5] = '{0, 1, 1'b1, 9};

    reset = 1'b1;
    set_in(0, 1'b0, '0, 1'b0, 1'b0);
    set_in(1, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset%0d req_ready", k), get_rdy(k), 1);
      check($sformatf("reset%0d rom_en", k), get_ren(k), 0);
      check($sformatf("reset%0d rom_addr", k), k != 0 ? MW'(addr_b) : MW'(addr_a), 0);
      check($sformatf("reset%0d mat", k), get_mat(k), 0);
      check($sformatf("reset%0d mat_valid", k), get_mv(k), 0);
      check($sformatf("reset%0d done_pulse", k), get_dp(k), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i].d, tbl[i].g, tbl[i].adj, 1'b0, -1, lat, nrom, bad, mv0);
      check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d rom words", i), nrom, tbl[i].d != 0 ? 2 : 8);
      check($sformatf("vec%0d addr seq", i), bad, 0);
      check($sformatf("vec%0d valid cleared", i), mv0, 0);
      check($sformatf("vec%0d mat", i), get_mat(tbl[i].d), model(tbl[i].g, tbl[i].adj));
      check($sformatf("vec%0d mat_valid", i), get_mv(tbl[i].d), 1);
    end

    run_load(1, 1, 1'b1, 1'b0, -1, lat, nrom, bad, mv0);
    m = get_mat(1);
    check("adj lat", lat, 3);
    check("adj o01 re", elem(m, 2), c19(-7));
    check("adj o01 im", elem(m, 3), c19(-3));
    check("adj o10 re", elem(m, 4), c19(100));
    check("adj o10 im", elem(m, 5), c19(-50));

    run_load(0, 7, 1'b1, 1'b0, -1, lat, nrom, bad, mv0);
    m = get_mat(0);
    check("sat o00 im", elem(m, 1), c19(262143));
    check("sat o10 im", elem(m, 5), c19(262143));

    // Reset two cycles into a LANES=1 load.
    set_in(0, 1'b1, GW'(3), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, GW'(3), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort mat", mat_a, 0);
    check("abort mat_valid", mv_a, 0);
    check("abort req_ready", rdy_a, 1);
    check("abort rom_en", ren_a, 0);
    ndp = 0;
    repeat (15) begin
      @(negedge clk);
      if (dp_a) ndp++;
    end
    check("abort no done", ndp, 0);

    // Back-to-back, with a stray request while busy.
    run_load(0, 2, 1'b0, 1'b0, 3, lat, nrom, bad, mv0);
    check("b2b first lat", lat, 9);
    check("b2b first addr", bad, 0);
    check("b2b first mat", mat_a, model(2, 1'b0));
    check("b2b ready at done", rdy_a, 1);
    run_load(0, 4, 1'b1, 1'b0, -1, lat, nrom, bad, mv0);
    check("b2b second lat", lat, 9);
    check("b2b second words", nrom, 8);
    check("b2b second addr", bad, 0);
    check("b2b second cleared", mv0, 0);
    check("b2b second mat", mat_a, model(4, 1'b1));
    ndp = 0;
    repeat (5) begin
      @(negedge clk);
      if (ren_a || dp_a) ndp++;
    end
    check("b2b idle after", ndp, 0);

    // Repeat of the same gate, then flush, then the adjoint of it.
    run_load(0, 5, 1'b0, 1'b0, -1, lat, nrom, bad, mv0);
    check("rep first lat", lat, 9);
    check("rep first mat", mat_a, model(5, 1'b0));
    run_load(0, 5, 1'b0, 1'b0, -1, lat, nrom, bad, mv0);
`ifdef GATE_MATRIX_CACHE_EN
    check("rep hit lat", lat, 1);
    check("rep hit words", nrom, 0);
    check("rep hit valid kept", mv0, 1);
`else
    check("rep reload lat", lat, 9);
    check("rep reload words", nrom, 8);
    check("rep reload cleared", mv0, 0);
`endif
    check("rep mat", mat_a, model(5, 1'b0));
    run_load(0, 5, 1'b0, 1'b1, -1, lat, nrom, bad, mv0);
    check("flush lat", lat, 9);
    check("flush words", nrom, 8);
    run_load(0, 5, 1'b1, 1'b0, -1, lat, nrom, bad, mv0);
    check("rep adj lat", lat, 9);
    check("rep adj words", nrom, 8);
    check("rep adj mat", mat_a, model(5, 1'b1));

    for (int i = 0; i < 24; i++) begin
      d    = int'($urandom_range(0, 1));
      g    = int'($urandom_range(0, 31));
      adj  = 1'($urandom_range(0, 1));
      poke = ($urandom_range(0, 1) != 0) ? 0 : -1;
      run_load(d, g, adj, 1'b0, poke, lat, nrom, bad, mv0);
`ifndef GATE_MATRIX_CACHE_EN
      check($sformatf("rnd%0d lat", i), lat, d != 0 ? 3 : 9);
`endif
      check($sformatf("rnd%0d addr", i), bad, 0);
      check($sformatf("rnd%0d mat", i), get_mat(d), model(g, adj));
      check($sformatf("rnd%0d mat_valid", i), get_mv(d), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
